// File: rtl/ldst_unit_pkg.sv
// ldst_unit_pkg
// Shared definitions for the load/store unit: FSM state encoding, pointer
// update codes, pointer addressing modes, the request timeout limit and the
// effective-address helper.
package ldst_unit_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PREDEC = 3'd1,
    ST_ADDR   = 3'd2,
    ST_REQ    = 3'd3,
    ST_WB     = 3'd4,
    ST_POST   = 3'd5
  } state_t;

  // Pointer update codes sent to the register file.
  localparam logic [1:0] RH_HOLD = 2'b00;
  localparam logic [1:0] RH_INC  = 2'b01;
  localparam logic [1:0] RH_DEC  = 2'b10;

  // Pointer addressing modes.
  localparam logic [1:0] PM_DISP    = 2'b00;
  localparam logic [1:0] PM_POSTINC = 2'b01;
  localparam logic [1:0] PM_PREDEC  = 2'b10;
  localparam logic [1:0] PM_PLAIN   = 2'b11;

  // Number of ack-less REQ cycles after which the request is abandoned.
  localparam logic [7:0] TIMEOUT = 8'd255;

  // Effective address: only the displacement mode adds disp; the sum wraps
  // modulo 2^16 by construction of the 16-bit result.
  function automatic logic [ADDR_W-1:0] eff_addr(input logic [ADDR_W-1:0] base,
                                                 input logic [1:0]        mode,
                                                 input logic [5:0]        disp);
    if (mode == PM_DISP) eff_addr = base + {10'd0, disp};
    else                 eff_addr = base;
  endfunction

endpackage

// File: rtl/ldst_unit.sv
// ldst_unit
// Single-operation load/store sequencer between a pointer register file and
// a request/acknowledge memory port.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   start         begin an operation (sampled only in IDLE)
//   is_store      1 = store rr_in, 0 = load into Rd
//   ptr_mode      00 disp, 01 post-inc, 10 pre-dec, 11 plain
//   ptr_sel       pointer pair select, latched and forwarded on rh_sel
//   disp          unsigned displacement (mode 00 only)
//   rh_in         pointer value from the register file
//   rr_in         store data
//   rh_sel/rh_op  pointer select / update request to the register file
//   rd_wr_en/rd_data  register writeback
//   mem_req/mem_we/mem_addr/mem_wdata/mem_ack/mem_rdata  memory port
//   busy          not in IDLE
//   done          one-cycle completion pulse
//   err           one-cycle timeout pulse
module ldst_unit
  import ldst_unit_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              is_store,
  input  logic [1:0]        ptr_mode,
  input  logic [1:0]        ptr_sel,
  input  logic [5:0]        disp,
  input  logic [ADDR_W-1:0] rh_in,
  input  logic [DATA_W-1:0] rr_in,
  output logic [1:0]        rh_sel,
  output logic [1:0]        rh_op,
  output logic              rd_wr_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              done,
  output logic              err
);

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_is_store;
  logic [1:0]          r_ptr_mode;
  logic [1:0]          r_ptr_sel;
  logic [5:0]          r_disp;
  logic [DATA_W-1:0]   r_rr;
  logic [7:0]          r_wait;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_rd_data;
  logic                r_err;
  logic [7:0]          w_wait_inc;
  logic                w_timeout;

  assign w_wait_inc = r_wait + 8'd1;

  // Next state and state-decoded outputs
  always_comb begin
    w_state_nxt = r_state;
    w_timeout   = 1'b0;
    rh_op       = RH_HOLD;
    rd_wr_en    = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_wdata   = '0;
    done        = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (start) w_state_nxt = (ptr_mode == PM_PREDEC) ? ST_PREDEC : ST_ADDR;
      end
      ST_PREDEC: begin
        rh_op       = RH_DEC;
        w_state_nxt = ST_ADDR;
      end
      ST_ADDR: begin
        w_state_nxt = ST_REQ;
      end
      ST_REQ: begin
        mem_req   = 1'b1;
        mem_we    = r_is_store;
        mem_wdata = r_rr;
        // An ack on the final allowed cycle still wins over the timeout.
        if (mem_ack) begin
          w_state_nxt = r_is_store ? ST_POST : ST_WB;
        end else if (w_wait_inc == TIMEOUT) begin
          w_state_nxt = ST_IDLE;
          w_timeout   = 1'b1;
        end
      end
      ST_WB: begin
        rd_wr_en    = 1'b1;
        w_state_nxt = ST_POST;
      end
      ST_POST: begin
        done        = 1'b1;
        rh_op       = (r_ptr_mode == PM_POSTINC) ? RH_INC : RH_HOLD;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State, operation latches and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_is_store <= 1'b0;
      r_ptr_mode <= PM_DISP;
      r_ptr_sel  <= 2'b00;
      r_disp     <= '0;
      r_rr       <= '0;
      r_wait     <= '0;
      r_addr     <= '0;
      r_rd_data  <= '0;
      r_err      <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      // err is raised in the cycle after the last REQ cycle, with mem_req low.
      r_err   <= w_timeout;
      if (r_state == ST_IDLE && start) begin
        r_is_store <= is_store;
        r_ptr_mode <= ptr_mode;
        r_ptr_sel  <= ptr_sel;
        r_disp     <= disp;
        r_rr       <= rr_in;
      end
      if (r_state == ST_ADDR) begin
        r_addr <= eff_addr(rh_in, r_ptr_mode, r_disp);
        r_wait <= '0;
      end
      if (r_state == ST_REQ) begin
        if (mem_ack) begin
          if (!r_is_store) r_rd_data <= mem_rdata;
        end else begin
          r_wait <= w_wait_inc;
        end
      end
    end
  end

  assign rh_sel   = r_ptr_sel;
  assign mem_addr = r_addr;
  assign rd_data  = r_rd_data;
  assign err      = r_err;
  assign busy     = (r_state != ST_IDLE);

endmodule

// File: doc/ldst_unit.md
LDST_UNIT -- requirements
Module: ldst_unit

Interface
REQ-001 The port list SHALL be as follows, one port per line: name, direction, width, meaning; there is one clock, reset is synchronous and active-high, and the clock and reset ports are named clk and rst.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin one load/store; sampled in IDLE only.
- is_store  in  1  1 = store rr_in to memory; 0 = load from memory into Rd.
- ptr_mode  in  2  00 = plain+displacement, 01 = post-increment, 10 = pre-decrement, 11 = plain with no displacement.
- ptr_sel  in  2  pointer pair select (X/Y/Z) forwarded to the register file.
- disp  in  6  unsigned displacement, used only when ptr_mode=00.
- rh_in  in  16  pointer value, driven from the register file 16-bit pair output.
- rr_in  in  8  store data.
- rh_sel  out  2  pointer pair select to the register file.
- rh_op  out  2  pointer update to the register file: 00 = hold, 01 = increment, 10 = decrement.
- rd_wr_en  out  1  register write enable.
- rd_data  out  8  register write data (load result).
- mem_req  out  1  memory request.
- mem_we  out  1  memory write enable.
- mem_addr  out  16  memory address.
- mem_wdata  out  8  memory write data.
- mem_ack  in  1  memory acknowledge.
- mem_rdata  in  8  memory read data.
- busy  out  1  unit not in IDLE.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle timeout pulse.

Function
REQ-002 The FSM SHALL have states IDLE, PREDEC, ADDR, REQ, WB and POST, encoded as a registered state.
REQ-003 In IDLE with start=1, the unit SHALL latch is_store, ptr_mode, ptr_sel, disp and rr_in, then go to PREDEC if ptr_mode=10, else to ADDR.
REQ-004 start SHALL be ignored in every state except IDLE.
REQ-005 PREDEC SHALL drive rh_op=10 for exactly one cycle, then go to ADDR.
REQ-006 ADDR SHALL register mem_addr as rh_in + zero-extended disp (modulo 2^16) when ptr_mode=00, else as rh_in, then go to REQ.
REQ-007 REQ SHALL hold mem_req=1, with mem_we=latched is_store and mem_wdata=latched rr_in, until mem_ack=1 is sampled on a rising edge.
REQ-008 On that ack edge, a load SHALL capture mem_rdata into rd_data and go to WB; a store SHALL go to POST.
REQ-009 WB SHALL drive rd_wr_en=1 for exactly one cycle, then go to POST.
REQ-010 POST SHALL drive done=1, and rh_op=01 if ptr_mode=01 (else rh_op=00), for one cycle, then go to IDLE.
REQ-011 The address wrap cases 0x0000-1 and 0xFFFF+disp SHALL wrap modulo 2^16 with no flag.
REQ-012 rh_sel SHALL equal the latched ptr_sel from the cycle after start until IDLE is re-entered.
REQ-013 A wait counter SHALL clear on entry to REQ and increment each REQ cycle without ack.
REQ-014 If the wait counter reaches 255 with no ack, the unit SHALL drop mem_req, pulse err for one cycle, perform no writeback and no post-increment, and return to IDLE; any PREDEC decrement already applied SHALL remain.
REQ-015 mem_ack SHALL be ignored outside REQ.
REQ-016 rh_op SHALL be 00, and rd_wr_en, mem_req and done SHALL be 0, in every state not named above for them.
REQ-017 busy SHALL be 1 exactly when state is not IDLE.
REQ-018 Latency SHALL be: plain load with immediate ack, start edge to done = 4 cycles; a pre-decrement operation adds 1 cycle; a store omits WB, so one fewer cycle.

Reset
REQ-019 While rst=1 at a rising edge, the state SHALL go to IDLE and the wait counter SHALL clear.
REQ-020 While rst=1 at a rising edge, every output SHALL go to 0, including mem_addr, rd_data, rh_sel and rh_op.
REQ-021 rst in any state, including mid-REQ, SHALL abandon the operation with no done, no err and no register or pointer update.

Structure
REQ-022 The shared package SHALL hold the state enum, the rh_op codes (HOLD/INC/DEC), the ptr_mode codes, and TIMEOUT=255.
REQ-023 The design SHALL be a single module with no sub-modules; the wait counter is inline.

Verification
REQ-024 Load, ptr_mode=00, rh_in=0x0100, disp=5, ack in the first REQ cycle, mem_rdata=0xA5 -> mem_addr=0x0105, rd_wr_en pulse with rd_data=0xA5, done 4 cycles after start.
REQ-025 Store, ptr_mode=01, rh_in=0x00FF, rr_in=0x3C -> mem_we=1, mem_addr=0x00FF, mem_wdata=0x3C, rh_op=01 in the done cycle, no rd_wr_en.
REQ-026 Load, ptr_mode=10, rh_in=0x0000 before PREDEC and 0xFFFF after -> rh_op=10 one cycle, mem_addr=0xFFFF, done at cycle 5.
REQ-027 mem_ack withheld for 255 REQ cycles -> err pulse, no done, no rd_wr_en, no rh_op=01, busy=0 the next cycle.
REQ-028 rst asserted during REQ (ack=0) -> next cycle all outputs 0, IDLE; a later start runs normally.
REQ-029 start held high throughout an operation -> the second operation begins only from IDLE; done pulses once per operation.
